// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_if
// Description : Byte-stream and instruction-memory write bundle for the
//               imem_loader. The master modport is the loader side; the
//               slave modport is the byte source / memory / core side.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        restart;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        load_done;
    logic        load_err;

    modport master (
        input  rx_valid, rx_data, restart,
        output rx_ready, imem_we, imem_addr, imem_wdata,
        output core_rst, load_done, load_err
    );

    modport slave (
        output rx_valid, rx_data, restart,
        input  rx_ready, imem_we, imem_addr, imem_wdata,
        input  core_rst, load_done, load_err
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Receives a framed byte stream (SYNC, N lo, N hi, N LE words,
//               optional XOR checksum), writes the words sequentially into
//               instruction memory and holds the core in reset until the
//               image is loaded. Defining IMEM_LOADER_CSUM_EN adds the
//               trailing checksum byte and its CSUM state.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN0  = 3'd1,
        S_LEN1  = 3'd2,
        S_DATA  = 3'd3,
`ifdef IMEM_LOADER_CSUM_EN
        S_CSUM  = 3'd4,
`endif
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    state_t      r_state;
    logic [7:0]  r_len_lo;
    logic [15:0] r_n_words;
    logic [15:0] r_word_idx;
    logic [1:0]  r_byte_cnt;
    logic [23:0] r_word_buf;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]  r_csum;
`endif
    logic        r_imem_we;
    logic [31:0] r_imem_addr;
    logic [31:0] r_imem_wdata;
    logic        r_core_rst;
    logic        r_load_done;
    logic        r_load_err;

    logic        w_rx_ready;
    logic        w_accept;
    logic [15:0] w_len;
    logic        w_last_word;
    logic [31:0] w_word_addr;

    // Ready is a pure decode of the state: only the terminal states refuse bytes
    assign w_rx_ready  = (r_state != S_DONE) && (r_state != S_ERROR);
    assign w_accept    = bus.rx_valid && w_rx_ready;
    assign w_len       = {bus.rx_data, r_len_lo};
    assign w_last_word = (r_word_idx == (r_n_words - 16'd1));
    assign w_word_addr = BASE_ADDR + {14'd0, r_word_idx, 2'b00};

    assign bus.rx_ready   = w_rx_ready;
    assign bus.imem_we    = r_imem_we;
    assign bus.imem_addr  = r_imem_addr;
    assign bus.imem_wdata = r_imem_wdata;
    assign bus.core_rst   = r_core_rst;
    assign bus.load_done  = r_load_done;
    assign bus.load_err   = r_load_err;

    // Frame parser FSM with registered write port and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_len_lo     <= 8'h00;
            r_n_words    <= 16'h0000;
            r_word_idx   <= 16'h0000;
            r_byte_cnt   <= 2'd0;
            r_word_buf   <= 24'h000000;
`ifdef IMEM_LOADER_CSUM_EN
            r_csum       <= 8'h00;
`endif
            r_imem_we    <= 1'b0;
            r_imem_addr  <= BASE_ADDR;
            r_imem_wdata <= 32'h0000_0000;
            r_core_rst   <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse
            r_imem_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Anything other than the sync marker is dropped here
                    if (w_accept && (bus.rx_data == SYNC_BYTE)) begin
                        r_state <= S_LEN0;
                    end
                end
                S_LEN0: begin
                    if (w_accept) begin
                        r_len_lo <= bus.rx_data;
                        r_state  <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (w_accept) begin
                        r_n_words  <= w_len;
                        r_word_idx <= 16'h0000;
                        r_byte_cnt <= 2'd0;
`ifdef IMEM_LOADER_CSUM_EN
                        r_csum     <= 8'h00;
`endif
                        if ({16'd0, w_len} > DEPTH_WORDS) begin
                            r_state    <= S_ERROR;
                            r_load_err <= 1'b1;
                        end else if (w_len == 16'h0000) begin
`ifdef IMEM_LOADER_CSUM_EN
                            r_state     <= S_CSUM;
`else
                            r_state     <= S_DONE;
                            r_load_done <= 1'b1;
                            r_core_rst  <= 1'b0;
`endif
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
`ifdef IMEM_LOADER_CSUM_EN
                        r_csum <= r_csum ^ bus.rx_data;
`endif
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        case (r_byte_cnt)
                            2'd0: r_word_buf[7:0]   <= bus.rx_data;
                            2'd1: r_word_buf[15:8]  <= bus.rx_data;
                            2'd2: r_word_buf[23:16] <= bus.rx_data;
                            default: begin
                                // Fourth byte completes the word: write it out now
                                r_imem_we    <= 1'b1;
                                r_imem_addr  <= w_word_addr;
                                r_imem_wdata <= {bus.rx_data, r_word_buf};
                                r_word_idx   <= r_word_idx + 16'd1;
                                if (w_last_word) begin
`ifdef IMEM_LOADER_CSUM_EN
                                    r_state     <= S_CSUM;
`else
                                    r_state     <= S_DONE;
                                    r_load_done <= 1'b1;
                                    r_core_rst  <= 1'b0;
`endif
                                end
                            end
                        endcase
                    end
                end
`ifdef IMEM_LOADER_CSUM_EN
                S_CSUM: begin
                    if (w_accept) begin
                        if (bus.rx_data == r_csum) begin
                            r_state     <= S_DONE;
                            r_load_done <= 1'b1;
                            r_core_rst  <= 1'b0;
                        end else begin
                            r_state    <= S_ERROR;
                            r_load_err <= 1'b1;
                        end
                    end
                end
`endif
                S_DONE, S_ERROR: begin
                    // Re-arm for a new image; the core goes back into reset
                    if (bus.restart) begin
                        r_state     <= S_IDLE;
                        r_core_rst  <= 1'b1;
                        r_load_done <= 1'b0;
                        r_load_err  <= 1'b0;
                        r_word_idx  <= 16'h0000;
                        r_byte_cnt  <= 2'd0;
`ifdef IMEM_LOADER_CSUM_EN
                        r_csum      <= 8'h00;
`endif
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader: directed frame table,
//               randomized frames against a frame-level reference model,
//               and a mid-frame reset sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam logic [31:0] C_BASE  = 32'h0;
    localparam int          C_DEPTH = 1024;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          off;
    } wr_t;
    typedef struct {
        int          len;
        logic [7:0]  b [16];
        int          n_wr;
        logic [31:0] w0;
        logic        done;
        logic        err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    imem_loader_if bus();

    imem_loader #(
        .BASE_ADDR   (C_BASE),
        .DEPTH_WORDS (C_DEPTH),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  acc_cnt = 0;
    int  base    = 0;
    wr_t wr_q[$];
    wr_t exp_q[$];
    logic exp_done, exp_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Write/accept monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1)
            wr_q.push_back('{bus.imem_addr, bus.imem_wdata, acc_cnt - base});
        if (bus.rx_valid && bus.rx_ready && !rst)
            acc_cnt++;
    end

    // Frame-level reference: walk the byte list the way the frame format reads
    function automatic void model(input bq_t f);
        int   i;
        int   n;
        logic [7:0] cs;
        exp_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        cs = 8'h00;
        i = 0;
        while (i < f.size() && f[i] != 8'hA5) i++;
        if (i + 2 >= f.size()) return;
        n = int'(f[i+1]) + 256 * int'(f[i+2]);
        i += 3;
        if (n > C_DEPTH) begin
            exp_err = 1'b1;
            return;
        end
        for (int k = 0; k < n; k++) begin
            wr_t w;
            w.addr = C_BASE + 32'(4 * k);
            w.data = {f[i+3], f[i+2], f[i+1], f[i]};
            w.off  = i + 4;
            cs = cs ^ f[i] ^ f[i+1] ^ f[i+2] ^ f[i+3];
            exp_q.push_back(w);
            i += 4;
        end
`ifdef IMEM_LOADER_CSUM_EN
        if (f[i] == cs) exp_done = 1'b1;
        else            exp_err  = 1'b1;
`else
        exp_done = 1'b1;
`endif
    endfunction

    // Present one byte; it is consumed on the next rising edge
    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            bus.rx_valid = 1'b0;
            @(posedge clk); #2;
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk); #2;
        bus.rx_valid = 1'b0;
    endtask

    task automatic run_frame(input bq_t f, input int max_gap,
                             output logic fin_done, output logic fin_err);
        wr_q.delete();
        base = acc_cnt;
        model(f);
        foreach (f[i]) send_byte(f[i], (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
        fin_done = bus.load_done;
        fin_err  = bus.load_err;
        check("load_done", {31'd0, bus.load_done}, {31'd0, exp_done});
        check("load_err",  {31'd0, bus.load_err},  {31'd0, exp_err});
        check("core_rst",  {31'd0, bus.core_rst},  {31'd0, !exp_done});
        check("rx_ready",  {31'd0, bus.rx_ready},  {31'd0, !(exp_done || exp_err)});
        repeat (2) @(posedge clk);
        #2;
        check("wr_count", wr_q.size(), exp_q.size());
        foreach (exp_q[k]) begin
            if (k < wr_q.size()) begin
                check("wr_addr", wr_q[k].addr, exp_q[k].addr);
                check("wr_data", wr_q[k].data, exp_q[k].data);
                check("wr_time", wr_q[k].off, exp_q[k].off);
            end
        end
        if (exp_done || exp_err) begin
            bus.restart = 1'b1;
            @(posedge clk); #2;
            bus.restart = 1'b0;
            check("rst_core_rst", {31'd0, bus.core_rst},  32'd1);
            check("rst_done",     {31'd0, bus.load_done}, 32'd0);
            check("rst_err",      {31'd0, bus.load_err},  32'd0);
            check("rst_ready",    {31'd0, bus.rx_ready},  32'd1);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_we"},    {31'd0, bus.imem_we},   32'd0);
        check({tag, "_addr"},  bus.imem_addr,          C_BASE);
        check({tag, "_wdata"}, bus.imem_wdata,         32'd0);
        check({tag, "_core"},  {31'd0, bus.core_rst},  32'd1);
        check({tag, "_done"},  {31'd0, bus.load_done}, 32'd0);
        check({tag, "_err"},   {31'd0, bus.load_err},  32'd0);
        check({tag, "_ready"}, {31'd0, bus.rx_ready},  32'd1);
    endtask

    vec_t vecs[5];

    initial begin
        bq_t  f;
        logic d, e;

        // Directed frame table
`ifdef IMEM_LOADER_CSUM_EN
        vecs[0] = '{12, '{8'hA5,8'h02,8'h00,8'h13,8'h00,8'h00,8'h00,8'h93,8'h00,8'h10,8'h00,8'h90,0,0,0,0},
                    2, 32'h0000_0013, 1'b1, 1'b0};
        vecs[1] = '{15, '{8'h00,8'hFF,8'h5A,8'hA5,8'h02,8'h00,8'h13,8'h00,8'h00,8'h00,8'h93,8'h00,8'h10,8'h00,8'h90,0},
                    2, 32'h0000_0013, 1'b1, 1'b0};
        vecs[2] = '{12, '{8'hA5,8'h02,8'h00,8'h13,8'h00,8'h00,8'h00,8'h93,8'h00,8'h10,8'h00,8'h91,0,0,0,0},
                    2, 32'h0000_0013, 1'b0, 1'b1};
        vecs[4] = '{4,  '{8'hA5,8'h00,8'h00,8'h00,0,0,0,0,0,0,0,0,0,0,0,0},
                    0, 32'h0, 1'b1, 1'b0};
`else
        vecs[0] = '{11, '{8'hA5,8'h02,8'h00,8'h13,8'h00,8'h00,8'h00,8'h93,8'h00,8'h10,8'h00,0,0,0,0,0},
                    2, 32'h0000_0013, 1'b1, 1'b0};
        vecs[1] = '{14, '{8'h00,8'hFF,8'h5A,8'hA5,8'h02,8'h00,8'h13,8'h00,8'h00,8'h00,8'h93,8'h00,8'h10,8'h00,0,0},
                    2, 32'h0000_0013, 1'b1, 1'b0};
        vecs[2] = '{7,  '{8'hA5,8'h01,8'h00,8'hEF,8'hBE,8'hAD,8'hDE,0,0,0,0,0,0,0,0,0},
                    1, 32'hDEAD_BEEF, 1'b1, 1'b0};
        vecs[4] = '{3,  '{8'hA5,8'h00,8'h00,0,0,0,0,0,0,0,0,0,0,0,0,0},
                    0, 32'h0, 1'b1, 1'b0};
`endif
        vecs[3] = '{3,  '{8'hA5,8'h01,8'h04,0,0,0,0,0,0,0,0,0,0,0,0,0},
                    0, 32'h0, 1'b0, 1'b1};

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.restart  = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        check_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #2;

        foreach (vecs[v]) begin
            f.delete();
            for (int i = 0; i < vecs[v].len; i++) f.push_back(vecs[v].b[i]);
            run_frame(f, (v == 0) ? 2 : 0, d, e);
            check("tbl_nwr",  wr_q.size(), vecs[v].n_wr);
            if (vecs[v].n_wr > 0) check("tbl_w0", wr_q[0].data, vecs[v].w0);
            check("tbl_done", {31'd0, d}, {31'd0, vecs[v].done});
            check("tbl_err",  {31'd0, e}, {31'd0, vecs[v].err});
        end

        // Randomized frames with gaps, leading junk, oversize and bad checksums
        for (int t = 0; t < 25; t++) begin
            int         n;
            logic [7:0] cs;
            f.delete();
            cs = 8'h00;
            repeat ($urandom_range(0, 3)) f.push_back(8'($urandom_range(0, 8'hA4)));
            f.push_back(8'hA5);
            n = ($urandom_range(0, 9) == 0) ? $urandom_range(C_DEPTH + 1, 65535)
                                            : $urandom_range(0, 5);
            f.push_back(8'(n));
            f.push_back(8'(n >> 8));
            if (n <= C_DEPTH) begin
                for (int i = 0; i < 4 * n; i++) begin
                    logic [7:0] b;
                    b = 8'($urandom);
                    cs ^= b;
                    f.push_back(b);
                end
`ifdef IMEM_LOADER_CSUM_EN
                if ($urandom_range(0, 2) == 0) cs ^= 8'($urandom_range(1, 255));
                f.push_back(cs);
`endif
            end
            run_frame(f, $urandom_range(0, 3), d, e);
        end

        // Reset after two data bytes: no write, outputs back to reset values
        wr_q.delete();
        base = acc_cnt;
        send_byte(8'hA5, 0);
        send_byte(8'h02, 1);
        send_byte(8'h00, 0);
        send_byte(8'h13, 2);
        send_byte(8'h00, 0);
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #2;
        check("midrst_nowr", wr_q.size(), 0);

        f.delete();
        for (int i = 0; i < vecs[0].len; i++) f.push_back(vecs[0].b[i]);
        run_frame(f, 1, d, e);
        check("reload_done", {31'd0, d}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
